// File: rtl/outputconditioner.sv
// -----------------------------------------------------------------------------
// outputconditioner
//
// Output-side counterpart of the input conditioner. Internal logic issues
// single-cycle set/clear request strobes. This block turns them into a clean,
// registered level on an external pin such as an LED, an SPI chip-select or a
// test line. After every transition the pin holds its level for at least
// 'waittime' cycles. During that dwell window one opposite-level request can
// be parked, and it is applied as soon as the window closes. Each pin
// transition is reported as a one-cycle edge pulse.
//
// Parameters
//   counterwidth : width of the dwell counter
//   waittime     : minimum cycles pinout holds a level after a transition;
//                  legal range 1 .. 2**counterwidth-1
//
// Ports
//   clk          : system clock, rising-edge active
//   reset        : synchronous, active-high reset
//   setpulse     : request pinout=1 (sampled every cycle)
//   clearpulse   : request pinout=0 (sampled every cycle)
//   pinout       : registered conditioned output level
//   positiveedge : one-cycle pulse in the cycle pinout has just become 1
//   negativeedge : one-cycle pulse in the cycle pinout has just become 0
//   busy         : dwell window active, so pinout may not change yet
//   pending      : a deferred opposite-level request is stored
//   dropped      : one-cycle pulse, setpulse and clearpulse were both high
// -----------------------------------------------------------------------------
module outputconditioner #(
  parameter int counterwidth = 3,
  parameter int waittime     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic setpulse,
  input  logic clearpulse,
  output logic pinout,
  output logic positiveedge,
  output logic negativeedge,
  output logic busy,
  output logic pending,
  output logic dropped
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    IDLE_HIGH = 2'd1,
    HOLD_LOW  = 2'd2,
    HOLD_HIGH = 2'd3
  } state_t;

  // The dwell ends once the counter reaches waittime-1. That value is always
  // below 2**counterwidth, so the counter never wraps.
  localparam logic [counterwidth-1:0] lastcount = counterwidth'(waittime - 1);

  state_t                  state;
  logic [counterwidth-1:0] count;

  logic reqvalid;
  logic reqlevel;
  logic conflict;
  logic holding;
  logic wantflip;
  logic pendnext;
  logic dwelldone;
  logic doflip;

  // Request decode and next-step decisions. When both strobes are high, the
  // request is dropped instead of being resolved by priority.
  always_comb begin
    conflict  = setpulse & clearpulse;
    reqvalid  = setpulse ^ clearpulse;
    reqlevel  = setpulse;
    holding   = (state == HOLD_LOW) || (state == HOLD_HIGH);
    wantflip  = reqvalid && (reqlevel != pinout);

    // Inside the dwell window the latest request wins. An opposite-level
    // request arms the slot and a same-level request cancels it.
    pendnext  = 1'b0;
    if (holding) begin
      pendnext = reqvalid ? wantflip : pending;
    end

    dwelldone = holding && (count == lastcount);

    // In IDLE, an opposite request flips the pin on the next edge. In HOLD,
    // the pin flips only at the end of the window, and only if a request is
    // armed. A request that arrives in that final cycle also counts.
    doflip    = holding ? (dwelldone && pendnext) : wantflip;
  end

  // All outputs are registered state. The edge pulses and dropped default
  // low every cycle, so each one lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE_LOW;
      count        <= '0;
      pinout       <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      busy         <= 1'b0;
      pending      <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      dropped      <= conflict;

      if (doflip) begin
        pinout       <= ~pinout;
        positiveedge <= ~pinout;
        negativeedge <= pinout;
        count        <= '0;
        busy         <= 1'b1;
        pending      <= 1'b0;
        state        <= pinout ? HOLD_LOW : HOLD_HIGH;
      end else if (dwelldone) begin
        count        <= '0;
        busy         <= 1'b0;
        pending      <= 1'b0;
        state        <= pinout ? IDLE_HIGH : IDLE_LOW;
      end else if (holding) begin
        count        <= count + 1'b1;
        pending      <= pendnext;
      end
    end
  end

endmodule

// File: doc/outputconditioner.md
Name: outputconditioner

Overview:
- Output-side counterpart of the input conditioner.
- Takes single-cycle set/clear request strobes from internal logic and drives a clean, registered level onto an external pin (LED, SPI chip-select, test line).
- Enforces a minimum dwell time between pin transitions, holds one deferred request, and reports transitions as one-cycle edge pulses.

Parameters:
- counterwidth, 3, width of dwell counter
- waittime, 3, minimum cycles pinout holds a level after any transition; legal range 1 .. 2^counterwidth-1

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- setpulse  input  1  request pinout=1; sampled every cycle
- clearpulse  input  1  request pinout=0; sampled every cycle
- pinout  output  1  registered conditioned output level
- positiveedge  output  1  high for the one cycle in which pinout has just become 1
- negativeedge  output  1  high for the one cycle in which pinout has just become 0
- busy  output  1  high while dwell window active (pinout may not change)
- pending  output  1  high while a deferred opposite-level request is stored
- dropped  output  1  one-cycle pulse when a request was discarded because setpulse and clearpulse were both high

Behaviour:
- Reset: synchronous, active-high. Sampled high at a clk edge, the next register values are:
  - pinout=0, positiveedge=0, negativeedge=0, busy=0, pending=0, dropped=0
  - state=IDLE_LOW, count=0, pending slot empty
- Reset overrides all requests in the same cycle; mid-dwell reset discards the pending request with no edge pulse.
- All outputs are registered (no combinational path from inputs to outputs).
- Request decode, per cycle:
  - setpulse & clearpulse: no request; dropped=1 next cycle; pending slot unchanged.
  - setpulse alone: target 1. clearpulse alone: target 0.
- States: IDLE_LOW, IDLE_HIGH, HOLD_LOW, HOLD_HIGH. HOLD_x means pinout=x and the dwell window is running.
- IDLE_x transitions:
  - Request for the opposite level: at the next edge pinout flips, the matching edge pulse is 1 for one cycle, count<=0, state<=HOLD_(new level), busy<=1.
  - Request equal to the current level: ignored.
  - Latency from request strobe to pinout change is 1 cycle.
- HOLD_x transitions:
  - count increments by 1 each cycle.
  - Opposite-level request: stored in the pending slot; pending<=1.
  - Same-level request: clears the pending slot; pending<=0 (cancel).
  - Latest request wins.
- End of dwell, when count==waittime-1, at the next edge:
  - If pending (including a request arriving in this same cycle): pinout flips, edge pulse fires, count<=0, pending<=0, state<=HOLD_(new level). Back-to-back dwells follow.
  - Else: state<=IDLE_x, busy<=0.
- Timing guarantees:
  - The first transition is at edge E0; the earliest next transition is at edge E0+waittime, so minimum dwell = waittime cycles.
  - busy is high from edge E0 through edge E0+waittime-1 when no request is pending.
- waittime=1: pinout may change on every cycle, and busy pulses for one cycle per transition.
- Counter never wraps, because the dwell ends at waittime-1 < 2^counterwidth.
- positiveedge and negativeedge are never high together. Each is high only in the cycle in which the pinout change is visible.

Test Plan (counterwidth=3, waittime=3):
- Reset held 2 cycles with setpulse=1 -> all outputs 0 throughout; pinout stays 0 after release until a new request.
- setpulse one cycle before edge E -> pinout=1 and positiveedge=1 at E; positiveedge=0 at E+1; busy=1 at E..E+2, busy=0 at E+3.
- setpulse before E, clearpulse before E+1 -> pending=1 at E+1..E+2; pinout=0 and negativeedge=1 at E+3; busy stays 1 through E+5.
- setpulse before E, clearpulse before E+1, setpulse before E+2 -> pending 1 then 0 at E+2; pinout stays 1; no negativeedge; busy=0 at E+3.
- setpulse and clearpulse together in IDLE_LOW -> dropped=1 for one cycle; pinout, busy and pending remain 0.
- setpulse, then clearpulse during dwell, then reset before E+2 -> at the reset edge pinout=0, pending=0, busy=0, negativeedge=0; no later transition.
